// File: rtl/pixel_scan_scheduler.sv
// pixel_scan_scheduler
//   Sequences scans of the IMG_DIM x IMG_DIM image port for the pixel engines.
//   mode=0: one raster pass (phase RASTER).
//   mode=1: per BLK_DIM x BLK_DIM block, AVG pass, VAR pass, a CALC gap waiting
//           for calc_done, then a RECON pass; blocks visited in raster order.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, mode         launch a scan (only from IDLE/DONE); mode sampled with start
//   ready               engine accepts the current beat
//   calc_done           engine finished L/H computation (only looked at in CALC)
//   row, col            current pixel address
//   scan_valid          row/col/phase describe a live beat
//   phase               0 RASTER, 1 AVG, 2 VAR, 3 RECON
//   first, last         first/last beat of the current pass (raster) or block pass
//   out_we              write strobe for RASTER and RECON beats
//   busy, done          busy outside IDLE/DONE; done is a level held in DONE
module pixel_scan_scheduler #(
  parameter int unsigned IMG_DIM = 64,
  parameter int unsigned BLK_DIM = 4,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              ready,
  input  logic              calc_done,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              scan_valid,
  output logic [1:0]        phase,
  output logic              first,
  output logic              last,
  output logic              out_we,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BLK_W = $clog2(BLK_DIM);
  localparam int unsigned IDX_W = ADDR_W - BLK_W;
  localparam logic [ADDR_W-1:0] IMG_MAX = ADDR_W'(IMG_DIM - 1);
  localparam logic [ADDR_W-1:0] BLK_MAX = ADDR_W'(BLK_DIM - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(IMG_DIM / BLK_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RASTER, S_AVG, S_VAR, S_CALC, S_RECON, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_RASTER = 2'd0, PH_AVG = 2'd1, PH_VAR = 2'd2, PH_RECON = 2'd3
  } phase_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] r_q, r_d, c_q, c_d;
  logic [IDX_W-1:0]  blk_r_q, blk_r_d, blk_c_q, blk_c_d;
  logic              scan_valid_q, scan_valid_d;
  phase_t            phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] lim;
  logic              accept, c_end, r_end, blk_end;

  // Raster walks the whole image with r/c; block mode keeps r/c inside the block.
  assign lim     = (state_q == S_RASTER) ? IMG_MAX : BLK_MAX;
  assign c_end   = (c_q == lim);
  assign r_end   = (r_q == lim);
  assign blk_end = (blk_r_q == IDX_MAX) && (blk_c_q == IDX_MAX);
  assign accept  = scan_valid_q & ready;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    blk_r_d = blk_r_q;
    blk_c_d = blk_c_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = mode ? S_AVG : S_RASTER;
          r_d     = '0;
          c_d     = '0;
          blk_r_d = '0;
          blk_c_d = '0;
        end
      end
      S_RASTER, S_AVG, S_VAR, S_RECON: begin
        if (accept) begin
          if (!c_end) begin
            c_d = c_q + 1'b1;
          end else begin
            c_d = '0;
            if (!r_end) begin
              r_d = r_q + 1'b1;
            end else begin
              // End of a pass: counters return to 0 for the next pass.
              r_d = '0;
              case (state_q)
                S_RASTER: state_d = S_DONE;
                S_AVG:    state_d = S_VAR;
                S_VAR:    state_d = S_CALC;
                S_RECON: begin
                  if (blk_end) begin
                    state_d = S_DONE;
                    blk_r_d = '0;
                    blk_c_d = '0;
                  end else begin
                    state_d = S_AVG;
                    if (blk_c_q == IDX_MAX) begin
                      blk_c_d = '0;
                      blk_r_d = blk_r_q + 1'b1;
                    end else begin
                      blk_c_d = blk_c_q + 1'b1;
                    end
                  end
                end
                default: state_d = state_q;
              endcase
            end
          end
        end
      end
      S_CALC: begin
        if (calc_done) state_d = S_RECON;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered.
  always_comb begin
    scan_valid_d = 1'b0;
    phase_d      = PH_RASTER;
    busy_d       = 1'b1;
    done_d       = 1'b0;
    case (state_d)
      S_RASTER: scan_valid_d = 1'b1;
      S_AVG:    begin scan_valid_d = 1'b1; phase_d = PH_AVG;   end
      S_VAR:    begin scan_valid_d = 1'b1; phase_d = PH_VAR;   end
      S_CALC:   phase_d = PH_VAR;
      S_RECON:  begin scan_valid_d = 1'b1; phase_d = PH_RECON; end
      S_DONE:   begin busy_d = 1'b0; done_d = 1'b1; end
      default:  busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      c_q          <= '0;
      blk_r_q      <= '0;
      blk_c_q      <= '0;
      scan_valid_q <= 1'b0;
      phase_q      <= PH_RASTER;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      blk_r_q      <= blk_r_d;
      blk_c_q      <= blk_c_d;
      scan_valid_q <= scan_valid_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Block indices are zero in raster mode and r/c stay below BLK_DIM in block
  // mode, so concatenation-OR forms blk*BLK_DIM + offset in both modes.
  assign row        = {blk_r_q, {BLK_W{1'b0}}} | r_q;
  assign col        = {blk_c_q, {BLK_W{1'b0}}} | c_q;
  assign scan_valid = scan_valid_q;
  assign phase      = phase_q;
  assign first      = scan_valid_q & (r_q == '0) & (c_q == '0);
  assign last       = scan_valid_q & r_end & c_end;
  assign out_we     = scan_valid_q & ready & ((phase_q == PH_RASTER) || (phase_q == PH_RECON));
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Self-checking bench for pixel_scan_scheduler: a reference beat list is built
// from nested image/block loops, pushed to a queue before each scan, and popped
// on every accepted beat.
module tb_pixel_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, mode, ready, calc_done;
  logic [5:0] row, col;
  logic       scan_valid;
  logic [1:0] phase;
  logic       first, last, out_we, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  // {row, col, phase, first, last, out_we}
  typedef logic [16:0] beat_t;
  beat_t exp_q[$];

  pixel_scan_scheduler #(.IMG_DIM(64), .BLK_DIM(4), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready),
    .calc_done(calc_done), .row(row), .col(col), .scan_valid(scan_valid),
    .phase(phase), .first(first), .last(last), .out_we(out_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(input int r, input int c, input int ph,
                               input bit f, input bit l, input bit we);
    return {6'(r), 6'(c), 2'(ph), f, l, we};
  endfunction

  task automatic load_raster();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        exp_q.push_back(mk(r, c, 0, (r == 0 && c == 0), (r == 63 && c == 63), 1'b1));
  endtask

  task automatic load_block();
    for (int br = 0; br < 16; br++)
      for (int bc = 0; bc < 16; bc++)
        for (int ph = 1; ph <= 3; ph++)
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              exp_q.push_back(mk(br * 4 + r, bc * 4 + c, ph,
                                 (r == 0 && c == 0), (r == 3 && c == 3), (ph == 3)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full scan and scores every cycle against the reference queue.
  task automatic run_scan(input bit m, input bit toggle, input int stall,
                          input bit spurious, input int max_cyc,
                          output int done_cyc, output int calc0_len);
    beat_t obs, exp_b, prev;
    bit    prev_hold, calc0_over;
    int    calc_cnt;
    prev_hold  = 1'b0;
    calc0_over = 1'b0;
    calc_cnt   = 0;
    prev       = '0;
    done_cyc   = 0;
    exp_q.delete();
    if (m) load_block();
    else   load_raster();
    start     = 1'b1;
    mode      = m;
    ready     = 1'b1;
    calc_done = 1'b1;
    tick();
    start = 1'b0;
    mode  = ~m;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      start = spurious && (cyc == 100 || cyc == 2000);
      ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (busy && !scan_valid) begin
        if (!calc0_over) calc_cnt++;
        calc_done = calc0_over || (calc_cnt > stall);
      end else begin
        if (calc_cnt > 0) calc0_over = 1'b1;
        calc_done = (stall == 0) ? 1'b1 : 1'(cyc % 2);
      end
      #1;
      if (cyc == 1) begin
        n_total++;
        if ({done, busy, scan_valid} !== 3'b011)
          $display("FAIL launch: done/busy/valid got %b expected 011", {done, busy, scan_valid});
        else n_pass++;
      end
      obs = {row, col, phase, first, last, out_we};
      if (prev_hold) begin
        n_total++;
        if (obs[16:1] !== prev[16:1])
          $display("FAIL hold cyc %0d: got %h expected %h", cyc, obs[16:1], prev[16:1]);
        else n_pass++;
      end
      if (scan_valid && ready) begin
        prev_hold = 1'b0;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat cyc %0d: got %h expected no further beat", cyc, obs);
        end else begin
          exp_b = exp_q.pop_front();
          if (obs !== exp_b)
            $display("FAIL beat cyc %0d: got %h expected %h", cyc, obs, exp_b);
          else n_pass++;
        end
      end else begin
        n_total++;
        if (out_we !== 1'b0)
          $display("FAIL idle_we cyc %0d: got %b expected 0", cyc, out_we);
        else n_pass++;
        prev_hold = scan_valid;
        prev      = obs;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    if (done_cyc == 0) begin
      n_total++;
      $display("FAIL timeout: done never rose within %0d cycles", max_cyc);
    end
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL leftover: got %0d unconsumed beats expected 0", exp_q.size());
    else n_pass++;
    calc0_len = calc_cnt;
    start     = 1'b0;
    calc_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 1'b1; ready = 1'b1; calc_done = 1'b1;
    tick();
    tick();
    n_total++;
    if ({row, col, phase, scan_valid, first, last, out_we, busy, done} !== 21'd0)
      $display("FAIL reset: got %h expected 0",
               {row, col, phase, scan_valid, first, last, out_we, busy, done});
    else n_pass++;
    rst = 1'b0; start = 1'b0;
    tick();
    n_total++;
    if ({row, col, phase, scan_valid, first, last, out_we, busy, done} !== 21'd0)
      $display("FAIL idle_after_reset: got %h expected 0",
               {row, col, phase, scan_valid, first, last, out_we, busy, done});
    else n_pass++;
  endtask

  task automatic test_raster();
    int dc, cl;
    run_scan(1'b0, 1'b0, 0, 1'b0, 5000, dc, cl);
    n_total++;
    if (dc !== 4097) $display("FAIL raster_done_cycle: got %0d expected 4097", dc);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({done, busy, scan_valid, out_we} !== 4'b1000)
        $display("FAIL done_hold: got %b expected 1000", {done, busy, scan_valid, out_we});
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int dc, cl;
    run_scan(1'b0, 1'b1, 0, 1'b0, 9000, dc, cl);
    n_total++;
    if (dc !== 8193) $display("FAIL backpressure_done_cycle: got %0d expected 8193", dc);
    else n_pass++;
  endtask

  task automatic test_block();
    int dc, cl;
    run_scan(1'b1, 1'b0, 0, 1'b0, 13000, dc, cl);
    n_total++;
    if (dc !== 12545) $display("FAIL block_done_cycle: got %0d expected 12545", dc);
    else n_pass++;
    n_total++;
    if (cl !== 1) $display("FAIL block_calc_len: got %0d expected 1", cl);
    else n_pass++;
  endtask

  task automatic test_calc_stall();
    int dc, cl;
    run_scan(1'b1, 1'b0, 10, 1'b0, 13000, dc, cl);
    n_total++;
    if (cl !== 11) $display("FAIL stall_calc_len: got %0d expected 11", cl);
    else n_pass++;
    n_total++;
    if (dc !== 12555) $display("FAIL stall_done_cycle: got %0d expected 12555", dc);
    else n_pass++;
  endtask

  task automatic test_spurious();
    int dc, cl;
    run_scan(1'b0, 1'b0, 0, 1'b1, 5000, dc, cl);
    n_total++;
    if (dc !== 4097) $display("FAIL spurious_done_cycle: got %0d expected 4097", dc);
    else n_pass++;
  endtask

  task automatic test_mid_rst();
    bit hit;
    hit = 1'b0;
    start = 1'b1; mode = 1'b1; ready = 1'b1; calc_done = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (scan_valid && phase == 2'd2 && row == 6'd4 && col == 6'd20) begin
        hit = 1'b1;
        rst = 1'b1;
        break;
      end
      tick();
    end
    n_total++;
    if (!hit) $display("FAIL mid_rst_reach: got no VAR beat at (4,20) expected one");
    else n_pass++;
    tick();
    n_total++;
    if ({row, col, phase, scan_valid, first, last, out_we, busy, done} !== 21'd0)
      $display("FAIL mid_rst_outputs: got %h expected 0",
               {row, col, phase, scan_valid, first, last, out_we, busy, done});
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if ({scan_valid, out_we, busy} !== 3'b000)
      $display("FAIL mid_rst_idle: got %b expected 000", {scan_valid, out_we, busy});
    else n_pass++;
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({scan_valid, phase, row, col, first, out_we} !== {1'b1, 2'd1, 6'd0, 6'd0, 1'b1, 1'b0})
      $display("FAIL mid_rst_restart: got %h expected %h",
               {scan_valid, phase, row, col, first, out_we},
               {1'b1, 2'd1, 6'd0, 6'd0, 1'b1, 1'b0});
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raster();
    test_backpressure();
    test_block();
    test_calc_stall();
    test_spurious();
    test_mid_rst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
